// File: rtl/sync_fifo.sv
// Small registered FIFO used as the event queue.
// The head word is read straight from a storage register, so rd_data carries no combinational path from push_data.
module sync_fifo #(
  parameter int W_DATA = 32,
  parameter int DEPTH  = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  logic [W_DATA-1:0]           push_data,
  input  logic                        pop,
  output logic [W_DATA-1:0]           rd_data,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(DEPTH+1)-1:0]  level
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [W_DATA-1:0] mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic              push_ok;
  logic              pop_ok;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  assign full    = (level_q == FULL_LVL);
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign rd_data = mem_q[rd_ptr_q];

  // A pop frees a slot on the same edge, so a push into a full queue is kept when it coincides with a pop.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop_ok)  rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_ok) mem_q[wr_ptr_q] <= push_data;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: rtl/stable_change_detect.sv
// Debounce-style filter: a word is accepted once it has been sampled STABLE_CYCLES+1 times in a row,
// and every accepted change is queued as an event for a downstream consumer.
//
// Handshake: an event transfers on a rising edge where out_valid && out_ready; out_valid never drops
// and out_data never changes while waiting for out_ready; out_ready without out_valid is ignored.
module stable_change_detect #(
  parameter int W_DATA        = 32,
  parameter int STABLE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [W_DATA-1:0] in_data,
  output logic [W_DATA-1:0] current,
  output logic [W_DATA-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overflow,
  input  logic              overflow_clr
);

  localparam int CW         = $clog2(STABLE_CYCLES + 1);
  localparam int FIFO_DEPTH = 2;
  localparam int LVL_W      = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0]    CNT_MAX  = CW'(STABLE_CYCLES);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);

  logic [W_DATA-1:0] in_q, in_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [W_DATA-1:0] current_q, current_d;
  logic              overflow_q, overflow_d;

  logic              accept;
  logic              pop;
  logic              drop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [LVL_W-1:0]  fifo_level;

  // cnt counts how many samples after the first have matched in_q; saturation keeps a held value accepted once.
  always_comb begin
    in_d  = in_data;
    cnt_d = cnt_q;
    if (in_data != in_q) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  assign accept = (cnt_q == CNT_MAX) && (in_q != current_q);
  assign pop    = out_ready && out_valid;
  assign drop   = accept && fifo_full && !pop;

  always_comb begin
    current_d  = current_q;
    overflow_d = overflow_q;
    if (accept)       current_d  = in_q;
    if (drop)         overflow_d = 1'b1;
    else if (overflow_clr) overflow_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_q       <= '0;
      cnt_q      <= '0;
      current_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      in_q       <= in_d;
      cnt_q      <= cnt_d;
      current_q  <= current_d;
      overflow_q <= overflow_d;
    end
  end

  sync_fifo #(
    .W_DATA (W_DATA),
    .DEPTH  (FIFO_DEPTH)
  ) u_event_q (
    .clk       (clk),
    .rst       (rst),
    .push      (accept),
    .push_data (in_q),
    .pop       (pop),
    .rd_data   (out_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  assign out_valid = !fifo_empty;
  assign current   = current_q;
  assign overflow  = overflow_q;

  // Queue status flags must stay consistent with the occupancy count.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (fifo_full == (fifo_level == FULL_LVL) && fifo_empty == (fifo_level == '0))
        else $error("event queue flags inconsistent with level");
    end
  end

endmodule
